// File: rtl/dclk_burst_sched_pkg.sv
// Shared definitions for the burst-scheduled ring clock divider:
// FSM state encoding and the len/hi clamping helpers applied at latch time.
package dclk_burst_sched_pkg;

   // Working width of the clamp helpers; wide enough for ring lengths up to 16.
   localparam int PLW = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Force a requested period into the legal range 2..maxlen.
   function automatic logic [PLW-1:0] clamp_len(input logic [PLW-1:0] len,
                                                input logic [PLW-1:0] maxlen);
      logic [PLW-1:0] r;
      if (len < 5'd2) begin
         r = 5'd2;
      end else if (len > maxlen) begin
         r = maxlen;
      end else begin
         r = len;
      end
      return r;
   endfunction

   // Keep at least one high and one low state per period; len is already clamped.
   function automatic logic [PLW-1:0] clamp_hi(input logic [PLW-1:0] hi,
                                               input logic [PLW-1:0] len);
      logic [PLW-1:0] r;
      if (hi == 5'd0) begin
         r = 5'd1;
      end else if (hi >= len) begin
         r = len - 5'd1;
      end else begin
         r = hi;
      end
      return r;
   endfunction

endpackage

// File: rtl/dclk_burst_sched_if.sv
// Request/grant bundle between peripheral engines (master) and the scheduler (slave).
interface dclk_burst_sched_if #(
   parameter int NREQ = 4,
   parameter int LW   = 4,
   parameter int CW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*LW-1:0] len;
   logic [NREQ*LW-1:0] hi;
   logic [NREQ*CW-1:0] cnt;
   logic               abort;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic               dclk;
   logic               done;
   logic [2:0]         done_id;

   modport master (output req, len, hi, cnt, abort,
                   input  gnt, busy, dclk, done, done_id);

   modport slave  (input  req, len, hi, cnt, abort,
                   output gnt, busy, dclk, done, done_id);
endinterface

// File: rtl/dclk_burst_sched_ring.sv
// One-hot ring of programmable length. Bit 0 is ring index 0; the ring shifts
// left each enabled cycle and reloads bit 0 after the last state, on clear,
// or whenever the register is found not to be one-hot.
module dclk_burst_sched_ring #(
   parameter int MAXLEN = 8,
   parameter int LW     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [LW-1:0]     len_i,
   output logic [MAXLEN-1:0] idx_o,
   output logic              wrap_o
);
   logic [MAXLEN-1:0] idx_q;
   logic [MAXLEN-1:0] idx_d;
   logic [MAXLEN-1:0] last_s;
   logic              onehot_s;

   // Legality check and mask of the final ring position for the current length.
   always_comb begin
      onehot_s = (idx_q != '0) && ((idx_q & (idx_q - MAXLEN'(1))) == '0);
      for (int i = 0; i < MAXLEN; i++) begin
         last_s[i] = (LW'(i) == (len_i - LW'(1)));
      end
   end

   assign wrap_o = onehot_s && ((idx_q & last_s) != '0);

   // Next ring position: reload index 0 on clear, corruption or wrap.
   always_comb begin
      if (clr_i || !onehot_s) begin
         idx_d = MAXLEN'(1);
      end else if (en_i) begin
         if (wrap_o) begin
            idx_d = MAXLEN'(1);
         end else begin
            idx_d = {idx_q[MAXLEN-2:0], 1'b0};
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // Ring state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= MAXLEN'(1);
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o = idx_q;
endmodule

// File: rtl/dclk_burst_sched.sv
// Round-robin burst scheduler that lends one one-hot ring divider to NREQ
// requesters. dclk is registered and computed from the ring's next position so
// it is aligned with the ring index without an extra cycle of lag.
module dclk_burst_sched
   import dclk_burst_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int MAXLEN = 8,
   parameter int LW     = 4,
   parameter int CW     = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   dclk_burst_sched_if.slave  bus
);
   state_e            state_q;
   logic [NREQ-1:0]   gnt_q;
   logic              busy_q;
   logic              dclk_q;
   logic              done_q;
   logic [2:0]        done_id_q;
   logic [2:0]        ptr_q;
   logic [2:0]        win_q;
   logic [LW-1:0]     len_q;
   logic [LW-1:0]     hi_q;
   logic [CW-1:0]     rem_q;

   logic [2:0]        win_s;
   logic              any_s;
   logic [LW-1:0]     len_raw_s, hi_raw_s, len_cl_s, hi_cl_s;
   logic [CW-1:0]     cnt_raw_s, cnt_cl_s;
   logic              cancel_s;
   logic              ring_clr_s, ring_en_s, ring_wrap_s;
   logic [MAXLEN-1:0] ring_idx_s;
   logic [MAXLEN-1:0] hi_next_mask_s;
   logic              dclk_nxt_s;

   // Round-robin search starting just after the last winner; the lowest
   // distance from the pointer is written last and therefore wins.
   always_comb begin
      int c;
      c     = 0;
      win_s = 3'd0;
      any_s = |bus.req;
      for (int k = NREQ; k >= 1; k--) begin
         c     = (int'(ptr_q) + k) % NREQ;
         win_s = bus.req[c] ? 3'(c) : win_s;
      end
   end

   assign len_raw_s = bus.len[int'(win_s)*LW +: LW];
   assign hi_raw_s  = bus.hi[int'(win_s)*LW +: LW];
   assign cnt_raw_s = bus.cnt[int'(win_s)*CW +: CW];
   assign len_cl_s  = LW'(clamp_len(PLW'(len_raw_s), PLW'(MAXLEN)));
   assign hi_cl_s   = LW'(clamp_hi(PLW'(hi_raw_s), PLW'(len_cl_s)));
   assign cnt_cl_s  = (cnt_raw_s == '0) ? CW'(1) : cnt_raw_s;

   // The winner's request is still present exactly when req overlaps the grant.
   assign cancel_s = bus.abort || ((bus.req & gnt_q) == '0);

   // Ring runs only in RUN; it is parked at index 0 otherwise or on cancel.
   always_comb begin
      if (state_q == ST_RUN) begin
         ring_en_s  = 1'b1;
         ring_clr_s = cancel_s;
      end else begin
         ring_en_s  = 1'b0;
         ring_clr_s = 1'b1;
      end
   end

   dclk_burst_sched_ring #(.MAXLEN(MAXLEN), .LW(LW)) u_ring (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (ring_clr_s),
      .en_i   (ring_en_s),
      .len_i  (len_q),
      .idx_o  (ring_idx_s),
      .wrap_o (ring_wrap_s)
   );

   // dclk for the next ring position: index 0 after a wrap, else index+1 < hi.
   always_comb begin
      for (int i = 0; i < MAXLEN; i++) begin
         hi_next_mask_s[i] = (LW'(i + 1) < hi_q);
      end
      if (ring_wrap_s) begin
         dclk_nxt_s = 1'b1;
      end else begin
         dclk_nxt_s = |(ring_idx_s & hi_next_mask_s);
      end
   end

   // Burst FSM with registered grant, busy, dclk and completion outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         dclk_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 3'd0;
         ptr_q     <= 3'(NREQ - 1);
         win_q     <= 3'd0;
         len_q     <= LW'(2);
         hi_q      <= LW'(1);
         rem_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_s) begin
                  ptr_q   <= win_s;
                  win_q   <= win_s;
                  len_q   <= len_cl_s;
                  hi_q    <= hi_cl_s;
                  rem_q   <= cnt_cl_s;
                  gnt_q   <= NREQ'(1) << win_s;
                  busy_q  <= 1'b1;
                  dclk_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  dclk_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cancel_s) begin
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  dclk_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (ring_wrap_s && (rem_q == CW'(1))) begin
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
                  dclk_q    <= 1'b0;
                  done_q    <= 1'b1;
                  done_id_q <= win_q;
                  state_q   <= ST_DONE;
               end else begin
                  dclk_q <= dclk_nxt_s;
                  if (ring_wrap_s) begin
                     rem_q <= rem_q - CW'(1);
                  end else begin
                     rem_q <= rem_q;
                  end
               end
            end
            ST_DONE: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               dclk_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               dclk_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.dclk    = dclk_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
endmodule
